fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 stallF  input  1  hazard unit: do not launch a new fetch.
REQ-005 stallD  input  1  hazard unit: hold the IF/ID register.
REQ-006 flushD  input  1  clear IF/ID to a bubble.
REQ-007 pcsrcD  input  1  taken branch/jump resolved in decode.
REQ-008 pcbranchD  input  32  redirect target, valid when pcsrcD=1.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  request address, word aligned.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  32  fetched instruction.
REQ-013 instrD, pcplus4D  output  32 each  IF/ID register contents.
REQ-014 validD  output  1  instrD holds a real instruction.
REQ-015 rsD, rtD  output  5 each  instrD[25:21], instrD[20:16], combinational, to hazard unit.
REQ-016 fetch_busy  output  1  high in WAIT while imem_ack=0.

Function
REQ-017 States IDLE, WAIT, HOLD; imem_req=1 only in WAIT, imem_addr=pcF always; addr held stable in WAIT until imem_ack.
REQ-018 IDLE: stallF=0 -> WAIT next cycle; else remain IDLE.
REQ-019 WAIT, ack, stallD=0, no squash: IF/ID <= {imem_rdata, pcF+4, valid=1}; pcF <= pcF+4; next state WAIT if stallF=0, else IDLE.
REQ-020 WAIT, ack, stallD=1: instruction captured in hold buffer, pcF <= pcF+4, -> HOLD; IF/ID unchanged.
REQ-021 HOLD: stallD=0 -> IF/ID loads hold buffer, -> WAIT if stallF=0 else IDLE.
REQ-022 WAIT without ack and stallD=0: IF/ID loads bubble (instrD=0, validD=0); one bubble per missing-ack cycle.
REQ-023 pcsrcD=1 in IDLE or HOLD: pcF <= pcbranchD same edge; HOLD buffer discarded, -> IDLE.
REQ-024 pcsrcD=1 in WAIT without ack: target stored, squash flag set; on later ack data discarded (bubble), pcF <= stored target, squash cleared, request not cancelled mid-flight.
REQ-025 pcsrcD=1 in WAIT with ack same cycle: returned data discarded, pcF <= pcbranchD.
REQ-026 flushD=1 forces IF/ID to bubble on that edge; flushD overrides stallD and any load.
REQ-027 pcF+4 arithmetic modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-028 imem_ack outside WAIT ignored.

Reset
REQ-029 rst_n=0 asynchronously: state IDLE, pcF=RESET_PC, squash=0, instrD=0, pcplus4D=0, validD=0, hold buffer=0; hence imem_req=0, fetch_busy=0.
REQ-030 Reset mid-WAIT abandons the outstanding request; first request after release is RESET_PC.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined: 32-bit outputs perf_fetch_cnt (increments per validD load) and perf_bubble_cnt (increments per bubble load), both reset to 0, wrap at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN: those ports and counters absent; all other behaviour identical.

Verification
REQ-033 Reset release, ack every WAIT cycle, stalls 0 -> imem_addr 0,4,8; instrD follows rdata one edge later, pcplus4D 4,8,12.
REQ-034 Ack at addr 8 with stallD=1 for 2 cycles -> HOLD, imem_req=0, instrD unchanged; stallD drop -> instrD = addr-8 data, next req addr 12.
REQ-035 imem_ack delayed 3 cycles at addr 4 -> fetch_busy=1 3 cycles, 3 bubbles (validD=0), addr stays 4.
REQ-036 pcsrcD=1, pcbranchD=0x40 while WAIT at 0x10 unacked -> ack data dropped, next request 0x40.
REQ-037 flushD and stallD both 1 -> validD=0, instrD=0 next edge.
REQ-038 rst_n low mid-WAIT at 0x20 -> outputs zero immediately; after release request addr RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage with IDLE/WAIT/HOLD request FSM,
//                a one-entry hold buffer for returns that arrive while decode
//                is stalled, a squash flag for redirects that overtake an
//                outstanding request, and the IF/ID pipeline register.
//                Optional macro FETCH_PERF_CNT_EN adds fetch/bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [4:0]  rsD,
    output logic [4:0]  rtD,
    output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic        squash_q,  squash_d;
    logic [31:0] target_q,  target_d;
    logic [31:0] hold_q,    hold_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q,   valid_d;

    logic [31:0] pc_plus4;
    logic        load_valid;
    logic        load_bubble;
    logic [31:0] load_instr;
    logic [31:0] load_pcplus4;

    assign pc_plus4   = pc_q + 32'd4;
    assign imem_req   = (state_q == ST_WAIT);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == ST_WAIT) && !imem_ack;
    assign instrD     = instr_q;
    assign pcplus4D   = pcplus4_q;
    assign validD     = valid_q;
    assign rsD        = instr_q[25:21];
    assign rtD        = instr_q[20:16];

    // Next-state, PC, hold buffer and IF/ID update decisions
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        target_d     = target_q;
        hold_d       = hold_q;
        instr_d      = instr_q;
        pcplus4_d    = pcplus4_q;
        valid_d      = valid_q;
        load_valid   = 1'b0;
        load_bubble  = 1'b0;
        load_instr   = 32'd0;
        load_pcplus4 = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (pcsrcD) begin
                    pc_d    = pcbranchD;
                    state_d = ST_IDLE;
                end else if (!stallF) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_ack) begin
                    if (pcsrcD) begin
                        // Redirect arriving with the data: the data is wrong-path
                        pc_d        = pcbranchD;
                        squash_d    = 1'b0;
                        load_bubble = !stallD;
                        state_d     = stallF ? ST_IDLE : ST_WAIT;
                    end else if (squash_q) begin
                        // Earlier redirect was waiting for this return to drain
                        pc_d        = target_q;
                        squash_d    = 1'b0;
                        load_bubble = !stallD;
                        state_d     = stallF ? ST_IDLE : ST_WAIT;
                    end else if (!stallD) begin
                        load_valid   = 1'b1;
                        load_instr   = imem_rdata;
                        load_pcplus4 = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = stallF ? ST_IDLE : ST_WAIT;
                    end else begin
                        // Decode cannot accept it yet; park it
                        hold_d  = imem_rdata;
                        pc_d    = pc_plus4;
                        state_d = ST_HOLD;
                    end
                end else begin
                    load_bubble = !stallD;
                    if (pcsrcD) begin
                        // Request stays in flight; remember where to go after it
                        target_d = pcbranchD;
                        squash_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (pcsrcD) begin
                    pc_d    = pcbranchD;
                    hold_d  = 32'd0;
                    state_d = ST_IDLE;
                end else if (!stallD) begin
                    // pc already advanced past the held word, so it is its pc+4
                    load_valid   = 1'b1;
                    load_instr   = hold_q;
                    load_pcplus4 = pc_q;
                    hold_d       = 32'd0;
                    state_d      = stallF ? ST_IDLE : ST_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over both a stall and any load
        if (flushD) begin
            load_valid  = 1'b0;
            load_bubble = 1'b1;
        end

        if (load_bubble) begin
            instr_d   = 32'd0;
            pcplus4_d = 32'd0;
            valid_d   = 1'b0;
        end else if (load_valid) begin
            instr_d   = load_instr;
            pcplus4_d = load_pcplus4;
            valid_d   = 1'b1;
        end
    end

    // State, PC, squash/target, hold buffer and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            squash_q  <= 1'b0;
            target_q  <= 32'd0;
            hold_q    <= 32'd0;
            instr_q   <= 32'd0;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            squash_q  <= squash_d;
            target_q  <= target_d;
            hold_q    <= hold_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q,  perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;

    // Count every IF/ID load, split by real instruction versus bubble
    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (load_bubble) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end else if (load_valid) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. Memory data is
//                a function of the address, {6'b0, a[6:2], a[6:2]+1, 16'hC0DE},
//                so every expected instruction word is known by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_tests;
    int n_fail;

    fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .pcsrcD     (pcsrcD),
        .pcbranchD  (pcbranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD),
        .rsD        (rsD),
        .rtD        (rtD),
        .fetch_busy (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word contents derived from the requested address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [4:0] f;
        f = a[6:2];
        return {6'd0, f, f + 5'd1, 16'hC0DE};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        pcsrcD    = 1'b0;
        pcbranchD = 32'd0;
        imem_ack  = 1'b0;
        #1;
        check_eq("rst_req",    {31'd0, imem_req},   32'd0);
        check_eq("rst_addr",   imem_addr,           32'd0);
        check_eq("rst_instr",  instrD,              32'd0);
        check_eq("rst_pc4",    pcplus4D,            32'd0);
        check_eq("rst_valid",  {31'd0, validD},     32'd0);
        check_eq("rst_busy",   {31'd0, fetch_busy}, 32'd0);
        tick();
        tick();
        rst_n    = 1'b1;
        imem_ack = 1'b1;                 // ack while IDLE must be ignored

        // IDLE -> WAIT at address 0
        tick();
        check_eq("idle_ack_ignored", {31'd0, validD},   32'd0);
        check_eq("first_req",        {31'd0, imem_req}, 32'd1);
        check_eq("first_addr",       imem_addr,         32'd0);

        // Fetch at 0
        tick();
        check_eq("f0_instr", instrD,    32'h0001_C0DE);
        check_eq("f0_pc4",   pcplus4D,  32'd4);
        check_eq("f0_valid", {31'd0, validD}, 32'd1);
        check_eq("f0_rs",    {27'd0, rsD}, 32'd0);
        check_eq("f0_rt",    {27'd0, rtD}, 32'd1);
        check_eq("addr4",    imem_addr, 32'd4);

        // Ack withheld for three cycles at address 4
        imem_ack = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("slow_busy", {31'd0, fetch_busy}, 32'd1);
            tick();
            check_eq("slow_bubble_v", {31'd0, validD}, 32'd0);
            check_eq("slow_bubble_i", instrD,          32'd0);
            check_eq("slow_addr",     imem_addr,       32'd4);
        end
        imem_ack = 1'b1;
        #1;
        check_eq("slow_busy_end", {31'd0, fetch_busy}, 32'd0);
        tick();
        check_eq("f4_instr", instrD,   32'h0022_C0DE);
        check_eq("f4_pc4",   pcplus4D, 32'd8);
        check_eq("addr8",    imem_addr, 32'd8);

        // Ack at 8 while decode stalled for two cycles
        stallD = 1'b1;
        tick();
        check_eq("hold_req",   {31'd0, imem_req}, 32'd0);
        check_eq("hold_instr", instrD,            32'h0022_C0DE);
        tick();
        check_eq("hold2_req",   {31'd0, imem_req}, 32'd0);
        check_eq("hold2_instr", instrD,            32'h0022_C0DE);
        stallD = 1'b0;
        tick();
        check_eq("unhold_instr", instrD,   32'h0043_C0DE);
        check_eq("unhold_pc4",   pcplus4D, 32'd12);
        check_eq("unhold_rs",    {27'd0, rsD}, 32'd2);
        check_eq("unhold_rt",    {27'd0, rtD}, 32'd3);
        check_eq("unhold_req",   {31'd0, imem_req}, 32'd1);
        check_eq("addr12",       imem_addr, 32'd12);

        // Fetch 12, then redirect while the request at 0x10 is unacked
        tick();
        check_eq("addr16", imem_addr, 32'h10);
        imem_ack  = 1'b0;
        pcsrcD    = 1'b1;
        pcbranchD = 32'h40;
        tick();
        check_eq("squash_addr_held", imem_addr, 32'h10);
        pcsrcD   = 1'b0;
        imem_ack = 1'b1;
        tick();
        check_eq("squash_drop_v", {31'd0, validD}, 32'd0);
        check_eq("squash_drop_i", instrD,          32'd0);
        check_eq("squash_target", imem_addr,       32'h40);
        tick();
        check_eq("f40_instr", instrD, 32'h0211_C0DE);
        check_eq("f40_rs",    {27'd0, rsD}, 32'd16);
        check_eq("f40_rt",    {27'd0, rtD}, 32'd17);
        check_eq("addr44",    imem_addr, 32'h44);

        // Redirect in the same cycle as the ack
        pcsrcD    = 1'b1;
        pcbranchD = 32'h80;
        tick();
        check_eq("redir_ack_v",    {31'd0, validD}, 32'd0);
        check_eq("redir_ack_addr", imem_addr,       32'h80);
        pcsrcD = 1'b0;
        tick();
        check_eq("f80_instr", instrD,   32'h0001_C0DE);
        check_eq("f80_pc4",   pcplus4D, 32'h84);

        // Flush together with stall: bubble wins, fetch parks in HOLD
        flushD = 1'b1;
        stallD = 1'b1;
        tick();
        check_eq("flush_v",   {31'd0, validD},   32'd0);
        check_eq("flush_i",   instrD,            32'd0);
        check_eq("flush_req", {31'd0, imem_req}, 32'd0);
        flushD    = 1'b0;
        pcsrcD    = 1'b1;
        pcbranchD = 32'h100;
        tick();
        check_eq("hold_redir_req",  {31'd0, imem_req}, 32'd0);
        check_eq("hold_redir_addr", imem_addr,         32'h100);
        pcsrcD = 1'b0;
        stallD = 1'b0;
        tick();
        check_eq("hold_discard_v", {31'd0, validD},   32'd0);
        check_eq("hold_redir_req2", {31'd0, imem_req}, 32'd1);
        check_eq("hold_redir_addr2", imem_addr,        32'h100);

        // Wrap of pc+4 at the top of the address space
        pcsrcD    = 1'b1;
        pcbranchD = 32'hFFFF_FFFC;
        tick();
        pcsrcD = 1'b0;
        tick();
        check_eq("wrap_instr", instrD,    32'h03E0_C0DE);
        check_eq("wrap_pc4",   pcplus4D,  32'd0);
        check_eq("wrap_addr",  imem_addr, 32'd0);

        // Ack with stallF: load then go IDLE; ack in IDLE ignored
        stallF = 1'b1;
        tick();
        check_eq("stallf_valid", {31'd0, validD},   32'd1);
        check_eq("stallf_pc4",   pcplus4D,          32'd4);
        check_eq("stallf_req",   {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("idle_stay_req",   {31'd0, imem_req}, 32'd0);
        check_eq("idle_stay_addr",  imem_addr,         32'd4);
        check_eq("idle_stay_instr", instrD,            32'h0001_C0DE);
        stallF   = 1'b0;
        imem_ack = 1'b0;
        tick();
        check_eq("idle_exit_req", {31'd0, imem_req}, 32'd1);

        // Move the outstanding request to 0x20 with IF/ID held valid
        imem_ack  = 1'b1;
        pcsrcD    = 1'b1;
        pcbranchD = 32'h20;
        stallD    = 1'b1;
        tick();
        pcsrcD   = 1'b0;
        imem_ack = 1'b0;
        tick();
        check_eq("pre_rst_addr",  imem_addr,           32'h20);
        check_eq("pre_rst_busy",  {31'd0, fetch_busy}, 32'd1);
        check_eq("pre_rst_valid", {31'd0, validD},     32'd1);

        // Asynchronous reset mid-WAIT
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   {31'd0, imem_req},   32'd0);
        check_eq("arst_busy",  {31'd0, fetch_busy}, 32'd0);
        check_eq("arst_addr",  imem_addr,           32'd0);
        check_eq("arst_instr", instrD,              32'd0);
        check_eq("arst_valid", {31'd0, validD},     32'd0);
        check_eq("arst_pc4",   pcplus4D,            32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("arst_perf_f", perf_fetch_cnt,  32'd0);
        check_eq("arst_perf_b", perf_bubble_cnt, 32'd0);
`endif
        tick();
        rst_n  = 1'b1;
        stallD = 1'b0;
        tick();
        check_eq("post_rst_req",  {31'd0, imem_req}, 32'd1);
        check_eq("post_rst_addr", imem_addr,         32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
